// File: rtl/bcd_up_counter_2d_pkg.sv
// Shared FSM encoding and BCD constants for the two-digit BCD up counter.
package bcd_up_counter_2d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    function automatic logic bcd_digit_ok(input logic [3:0] digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_up_counter_2d_digit.sv
// Single BCD digit up counter: load has priority over increment, wraps to 0 past limit.
module bcd_digit_up
    import bcd_up_counter_2d_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic [3:0] limit,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output logic [3:0] value,
    output logic       wrap
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    assign wrap  = inc && (value_q == limit);
    assign value = value_q;

    // Next digit value; anything at or above 9 also folds back to 0.
    always_comb begin
        value_d = value_q;
        if (ld) begin
            value_d = ld_val;
        end else if (inc) begin
            if ((value_q == limit) || (value_q >= BCD_MAX)) begin
                value_d = BCD_ZERO;
            end else begin
                value_d = value_q + 4'd1;
            end
        end else begin
            value_d = value_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up counter with run/pause FSM, load/clear and programmable terminal value.
module bcd_up_counter_2d
    import bcd_up_counter_2d_pkg::*;
#(
    parameter logic [3:0] MAX_TENS = 4'd5,
    parameter logic [3:0] MAX_ONES = 4'd9,
    parameter bit         WRAP     = 1'b1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_pause,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [3:0] value_tens,
    output logic [3:0] value_ones,
    output logic       carry,
    output logic       running
);

    state_e     state_q, state_d;
    logic       carry_q, carry_d;
    logic       running_q;
    logic       inc_s, ld_s;
    logic [3:0] ld_tens_s, ld_ones_s;
    logic [3:0] tens_s, ones_s;
    logic       ones_wrap_s, tens_wrap_s;
    logic       at_term_s, reach_term_s, load_ok_s;
    logic [3:0] next_tens_s, next_ones_s;

    assign at_term_s   = (tens_s == MAX_TENS) && (ones_s == MAX_ONES);
    assign next_ones_s = (ones_s == BCD_MAX) ? BCD_ZERO : (ones_s + 4'd1);
    assign next_tens_s = (ones_s == BCD_MAX) ? (tens_s + 4'd1) : tens_s;
    assign reach_term_s = (next_tens_s == MAX_TENS) && (next_ones_s == MAX_ONES);
    // Digit-wise BCD compare is numeric once both digits are known valid.
    assign load_ok_s = bcd_digit_ok(load_value[7:4]) && bcd_digit_ok(load_value[3:0])
                       && (load_value <= {MAX_TENS, MAX_ONES});

    // Plain increment enable: only the lowest-priority tick path, below terminal.
    always_comb begin
        inc_s = 1'b0;
        if (!clr && !load && !start_pause && (state_q == ST_RUN) && tick && !at_term_s) begin
            inc_s = 1'b1;
        end else begin
            inc_s = 1'b0;
        end
    end

    // Control FSM, digit load path and carry generation (clr > load > start_pause > tick).
    always_comb begin
        state_d   = state_q;
        carry_d   = 1'b0;
        ld_s      = 1'b0;
        ld_tens_s = BCD_ZERO;
        ld_ones_s = BCD_ZERO;
        if (clr) begin
            ld_s    = 1'b1;
            state_d = ST_IDLE;
        end else if (load) begin
            if (load_ok_s) begin
                ld_s      = 1'b1;
                ld_tens_s = load_value[7:4];
                ld_ones_s = load_value[3:0];
                if (state_q == ST_DONE) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = state_q;
                end
            end else begin
                state_d = state_q;
            end
        end else if (start_pause) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end else if ((state_q == ST_RUN) && tick) begin
            if (at_term_s) begin
                if (WRAP) begin
                    ld_s    = 1'b1;
                    carry_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end else if (tens_wrap_s) begin
                // Cannot happen for a valid terminal; keeps the digits in range regardless.
                ld_s = 1'b1;
            end else if (!WRAP && reach_term_s) begin
                carry_d = 1'b1;
                state_d = ST_DONE;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    bcd_digit_up u_ones (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (inc_s),
        .limit  (BCD_MAX),
        .ld     (ld_s),
        .ld_val (ld_ones_s),
        .value  (ones_s),
        .wrap   (ones_wrap_s)
    );

    bcd_digit_up u_tens (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (ones_wrap_s),
        .limit  (BCD_MAX),
        .ld     (ld_s),
        .ld_val (ld_tens_s),
        .value  (tens_s),
        .wrap   (tens_wrap_s)
    );

    // State, carry and running registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            carry_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            carry_q   <= carry_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign value_tens = tens_s;
    assign value_ones = ones_s;
    assign carry      = carry_q;
    assign running    = running_q;

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Bench for bcd_up_counter_2d: vector table, hand sequences and random run against a decimal model.
module tb_bcd_up_counter_2d;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start_pause = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [3:0] t1, o1, t0, o0;
    logic       c1, r1, c0, r0;

    bcd_up_counter_2d #(.MAX_TENS(4'd5), .MAX_ONES(4'd9), .WRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_pause(start_pause), .clr(clr),
        .load(load), .load_value(load_value), .value_tens(t1), .value_ones(o1),
        .carry(c1), .running(r1)
    );

    bcd_up_counter_2d #(.MAX_TENS(4'd5), .MAX_ONES(4'd9), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_pause(start_pause), .clr(clr),
        .load(load), .load_value(load_value), .value_tens(t0), .value_ones(o0),
        .carry(c0), .running(r0)
    );

    always #5 clk = ~clk;

    localparam int TERM = 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    int checks = 0;
    int errors = 0;
    int m_val[2];
    int m_st[2];
    int m_carry[2];

    typedef struct {
        bit         c;
        bit         l;
        logic [7:0] v;
        bit         s;
        bit         t;
        int         e_val;
        int         e_c;
        int         e_r;
    } vec_t;
    vec_t vecs[$];

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_val[w] = 0;
            m_st[w] = M_IDLE;
            m_carry[w] = 0;
        end
    endtask

    // Index 0 models WRAP=0, index 1 models WRAP=1.
    task automatic model_step();
        for (int w = 0; w < 2; w++) begin
            int lt;
            int lo;
            m_carry[w] = 0;
            lt = int'(load_value[7:4]);
            lo = int'(load_value[3:0]);
            if (clr) begin
                m_val[w] = 0;
                m_st[w] = M_IDLE;
            end else if (load) begin
                if (lt <= 9 && lo <= 9 && (lt * 10 + lo) <= TERM) begin
                    m_val[w] = lt * 10 + lo;
                    if (m_st[w] == M_DONE) m_st[w] = M_PAUSE;
                end
            end else if (start_pause) begin
                if (m_st[w] == M_RUN) m_st[w] = M_PAUSE;
                else if (m_st[w] != M_DONE) m_st[w] = M_RUN;
            end else if (m_st[w] == M_RUN && tick) begin
                if (m_val[w] == TERM) begin
                    if (w == 1) begin
                        m_val[w] = 0;
                        m_carry[w] = 1;
                    end else begin
                        m_st[w] = M_DONE;
                    end
                end else begin
                    m_val[w] = m_val[w] + 1;
                    if (w == 0 && m_val[w] == TERM) begin
                        m_carry[w] = 1;
                        m_st[w] = M_DONE;
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit c, input bit l, input logic [7:0] v, input bit s, input bit t);
        clr = c;
        load = l;
        load_value = v;
        start_pause = s;
        tick = t;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model();
        chk("w1_value", int'({t1, o1}), to_bcd(m_val[1]));
        chk("w1_carry", int'(c1), m_carry[1]);
        chk("w1_running", int'(r1), (m_st[1] == M_RUN) ? 1 : 0);
        chk("w0_value", int'({t0, o0}), to_bcd(m_val[0]));
        chk("w0_carry", int'(c0), m_carry[0]);
        chk("w0_running", int'(r0), (m_st[0] == M_RUN) ? 1 : 0);
    endtask

    task automatic add(input bit c, input bit l, input logic [7:0] v, input bit s, input bit t,
                       input int ev, input int ec, input int er);
        vec_t x;
        x.c = c; x.l = l; x.v = v; x.s = s; x.t = t;
        x.e_val = ev; x.e_c = ec; x.e_r = er;
        vecs.push_back(x);
    endtask

    task automatic chk0(input string name, input int ev, input int ec, input int er);
        chk({name, "_val"}, int'({t0, o0}), ev);
        chk({name, "_carry"}, int'(c0), ec);
        chk({name, "_run"}, int'(r0), er);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", int'({t1, o1}), 8'h00);
        chk("rst_carry", int'(c1), 0);
        chk("rst_running", int'(r1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table for the WRAP=1 instance, applied from the reset state.
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        for (int i = 1; i <= 10; i++) add(0, 0, 8'h00, 0, 1, to_bcd(i), 0, 1);
        add(0, 1, 8'h58, 0, 0, 8'h58, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'h59, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'h00, 1, 1);
        add(0, 0, 8'h00, 0, 1, 8'h01, 0, 1);
        add(0, 1, 8'h23, 0, 0, 8'h23, 0, 1);
        add(0, 0, 8'h00, 1, 1, 8'h23, 0, 0);
        add(0, 0, 8'h00, 0, 1, 8'h23, 0, 0);
        add(0, 0, 8'h00, 0, 1, 8'h23, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h23, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'h24, 0, 1);
        add(0, 1, 8'h6A, 0, 0, 8'h24, 0, 1);
        add(0, 1, 8'h3C, 0, 0, 8'h24, 0, 1);
        add(1, 1, 8'h45, 0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
        add(0, 1, 8'h45, 0, 0, 8'h45, 0, 1);
        add(0, 1, 8'h60, 0, 0, 8'h45, 0, 1);
        add(0, 1, 8'h30, 0, 1, 8'h30, 0, 1);
        add(0, 1, 8'h59, 0, 0, 8'h59, 0, 1);
        add(0, 0, 8'h00, 0, 1, 8'h00, 1, 1);
        add(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].l, vecs[i].v, vecs[i].s, vecs[i].t);
            cyc();
            chk($sformatf("vec%0d_val", i), int'({t1, o1}), vecs[i].e_val);
            chk($sformatf("vec%0d_carry", i), int'(c1), vecs[i].e_c);
            chk($sformatf("vec%0d_run", i), int'(r1), vecs[i].e_r);
        end

        // WRAP=0: hold at terminal, single carry, DONE ignores start_pause.
        drive(1, 0, 8'h00, 0, 0); cyc();
        drive(0, 1, 8'h57, 0, 0); cyc();
        drive(0, 0, 8'h00, 1, 0); cyc();
        chk0("w0_start", 8'h57, 0, 1);
        drive(0, 0, 8'h00, 0, 1); cyc(); chk0("w0_t1", 8'h58, 0, 1);
        cyc(); chk0("w0_t2", 8'h59, 1, 0);
        cyc(); chk0("w0_t3", 8'h59, 0, 0);
        cyc(); chk0("w0_t4", 8'h59, 0, 0);
        cyc(); chk0("w0_t5", 8'h59, 0, 0);
        drive(0, 0, 8'h00, 1, 0); cyc(); chk0("w0_sp_done", 8'h59, 0, 0);
        drive(0, 1, 8'h12, 0, 0); cyc(); chk0("w0_ld_done", 8'h12, 0, 0);
        drive(0, 0, 8'h00, 1, 0); cyc(); chk0("w0_resume", 8'h12, 0, 1);
        drive(1, 0, 8'h00, 0, 0); cyc(); chk0("w0_clr", 8'h00, 0, 0);

        // Asynchronous reset mid-count at 37.
        drive(0, 1, 8'h36, 0, 0); cyc();
        drive(0, 0, 8'h00, 1, 0); cyc();
        drive(0, 0, 8'h00, 0, 1); cyc();
        chk("pre_rst_val", int'({t1, o1}), 8'h37);
        drive(0, 0, 8'h00, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_val", int'({t1, o1}), 8'h00);
        chk("async_rst_carry", int'(c1), 0);
        chk("async_rst_run", int'(r1), 0);
        chk("async_rst_w0_val", int'({t0, o0}), 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random stimulus against the decimal model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] v;
            if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 255));
            else v = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, v,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 60);
            cyc();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
